// File: rtl/gcd_arb_pkg.sv
// Shared types and helpers for the GCD arbiter.
// Optional watchdog is enabled with GCD_ARB_TIMEOUT_EN.
package gcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int DEF_TIMEOUT = 1024;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_rr_picker.sv
// Rotate-priority picker: first set request at or after ptr,
// wrapping modulo N; outputs one-hot grant, its index and any.
module gcd_rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan farthest offset first so the nearest one wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin front end sharing one GCD datapath among requesters.
// GCD_ARB_TIMEOUT_EN adds a WAIT watchdog that reports rsp_err.
module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W       = 16
`ifdef GCD_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
`endif
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*W-1:0]       req_a,
  input  logic [NUM_REQ*W-1:0]       req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [W-1:0]               rsp_z,
  output logic [id_w(NUM_REQ)-1:0]   rsp_id,
  output logic                       rsp_err,
  output logic [W-1:0]               gcd_a,
  output logic [W-1:0]               gcd_b,
  output logic                       gcd_e,
  input  logic [W-1:0]               gcd_z,
  input  logic                       gcd_v,
  output logic                       busy
);

  localparam int IW = id_w(NUM_REQ);

  state_t              state;
  logic [IW-1:0]       ptr;
  logic [NUM_REQ-1:0]  gnt;
  logic [IW-1:0]       idx;
  logic                any;
  logic [IW-1:0]       ptr_nxt;

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] wd_cnt;
  logic          wd_hit;
  assign wd_hit = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign rsp_err = 1'b0;
`endif

  gcd_rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  // Ready is gated by reset so it drops the moment reset asserts.
  assign req_ready = (reset_n && state == IDLE) ? gnt : '0;

  assign ptr_nxt = (rsp_id == IW'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gcd_a     <= '0;
      gcd_b     <= '0;
      gcd_e     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_z     <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
      rsp_err   <= 1'b0;
      wd_cnt    <= '0;
`endif
    end else begin
      gcd_e <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            gcd_a  <= req_a[int'(idx)*W +: W];
            gcd_b  <= req_b[int'(idx)*W +: W];
            rsp_id <= idx;
            gcd_e  <= 1'b1;
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef GCD_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        WAIT: begin
          if (gcd_v) begin
            rsp_z     <= gcd_z;
            rsp_valid <= 1'b1;
            state     <= RESP;
`ifdef GCD_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
          end else if (wd_hit) begin
            rsp_z     <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            ptr       <= ptr_nxt;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Randomised and directed bench for gcd_arbiter with a GCD stand-in.
// Define GCD_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_gcd_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [W-1:0]   rsp_z;
  logic [1:0]     rsp_id;
  logic           rsp_err;
  logic [W-1:0]   gcd_a;
  logic [W-1:0]   gcd_b;
  logic           gcd_e;
  logic [W-1:0]   gcd_z;
  logic           gcd_v;
  logic           busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

`ifdef GCD_ARB_TIMEOUT_EN
  gcd_arbiter #(.NUM_REQ(N), .W(W), .TIMEOUT_CYCLES(8)) dut (
`else
  gcd_arbiter #(.NUM_REQ(N), .W(W)) dut (
`endif
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .gcd_a     (gcd_a),
    .gcd_b     (gcd_b),
    .gcd_e     (gcd_e),
    .gcd_z     (gcd_z),
    .gcd_v     (gcd_v),
    .busy      (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // GCD stand-in: loads on e, one Euclid step per cycle, v is a level.
  logic [W-1:0] mx = '0;
  logic [W-1:0] my = '0;
  logic         mv = 1'b0;
  logic         stuck = 1'b0;
  logic         stale_inj = 1'b0;
  logic         inj_en = 1'b0;

  assign gcd_z = mx;
  assign gcd_v = mv | stale_inj;

  always @(posedge clk) begin
    if (gcd_e) begin
      mx <= gcd_a;
      my <= gcd_b;
      mv <= (gcd_b == 0) && !stuck;
    end else if (!mv && !stuck) begin
      if (my == 0) mv <= 1'b1;
      else begin
        mx <= my;
        my <= mx % my;
      end
    end
  end

  // Fake a stale "valid" exactly across the ISSUE cycle.
  always @(negedge clk) stale_inj <= inj_en & gcd_e;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: round-robin order and expected result per grant.
  int           mptr = 0;
  bit           pend = 0;
  int           p_id, p_cyc, e_cnt;
  logic [W-1:0] p_a, p_b, p_z;
  bit           p_stuck, rsp_seen;
  int           last_lat, n_done = 0;
  logic [W-1:0] last_z;
  int           last_id;
  int           gq[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      mptr = 0;
      pend = 0;
    end else begin
      if (req_ready != 0) begin
        int exp_id;
        exp_id = -1;
        for (int k = 0; k < N; k++)
          if (exp_id < 0 && req_valid[(mptr + k) % N])
            exp_id = (mptr + k) % N;
        check("grant", req_ready, 32'(1) << exp_id);
        p_id     = exp_id;
        p_a      = req_a[exp_id*W +: W];
        p_b      = req_b[exp_id*W +: W];
        p_stuck  = stuck;
        p_z      = stuck ? '0 : ref_gcd(p_a, p_b);
        p_cyc    = cyc;
        pend     = 1;
        e_cnt    = 0;
        rsp_seen = 0;
        gq.push_back(exp_id);
      end
      if (gcd_e) begin
        e_cnt++;
        check("gcd_a", gcd_a, p_a);
        check("gcd_b", gcd_b, p_b);
        check("e_lat", cyc - p_cyc, 1);
      end
      if (rsp_valid) begin
        check("rsp_pend", pend, 1);
        check("rsp_z", rsp_z, p_z);
        check("rsp_id", rsp_id, p_id);
        check("rsp_err", rsp_err, p_stuck);
        check("rsp_rdy0", req_ready, 0);
        check("rsp_e0", gcd_e, 0);
        if (!rsp_seen) begin
          last_lat = cyc - p_cyc;
          rsp_seen = 1;
        end
        if (rsp_ready) begin
          check("e_cnt", e_cnt, 1);
          last_z  = rsp_z;
          last_id = rsp_id;
          mptr    = (p_id + 1) % N;
          pend    = 0;
          n_done++;
        end
      end
    end
  end

  task automatic take(input int id);
    bit got;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1;
        break;
      end
    end
    if (!got) check("grant_to", 0, 1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic issue(input int id,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    @(posedge clk);
    #1;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_valid[id] = 1'b1;
    take(id);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_to", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rv", rsp_valid, 0);
    check("rst_e", gcd_e, 0);
    check("rst_rdy", req_ready, 0);
    check("rst_ga", gcd_a, 0);
    reset_n = 1'b1;

    // 1) basic operation.
    issue(0, 16'd48, 16'd18);
    drain();
    check("t1_z", last_z, 6);
    check("t1_id", last_id, 0);

    // 2) all requesters continuously valid from reset.
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 16'($urandom_range(1, 999));
      req_b[i*W +: W] = 16'($urandom_range(1, 999));
    end
    req_valid = '1;
    gq.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (gq.size() >= 5) break;
    end
    @(posedge clk);
    #1 req_valid = '0;
    drain();
    check("t2_n", gq.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < gq.size()) check("t2_ord", gq[i], i % N);

    // 3) b=0 minimum latency, then a stale valid in ISSUE.
    issue(2, 16'd7, 16'd0);
    drain();
    check("t3_lat", last_lat, 3);
    check("t3_z", last_z, 7);
    inj_en = 1'b1;
    issue(3, 16'd48, 16'd18);
    drain();
    inj_en = 1'b0;
    check("t3_stale_z", last_z, 6);
    check("t3_stale_lat", 32'(last_lat > 3), 1);

    // 4) consumer back-pressure, with another request waiting.
    rsp_ready = 1'b0;
    issue(1, 16'd100, 16'd75);
    req_a[0*W +: W] = 16'd9;
    req_b[0*W +: W] = 16'd6;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    check("t4_rv", rsp_valid, 1);
    repeat (10) @(negedge clk);
    check("t4_hold_z", rsp_z, 25);
    check("t4_hold_id", rsp_id, 1);
    rsp_ready = 1'b1;
    take(0);
    drain();
    check("t4_z", last_z, 3);

    // 5) reset during WAIT, then a clean operation.
    stuck = 1'b1;
    issue(0, 16'd30, 16'd12);
    req_valid[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_e", gcd_e, 0);
    check("t5_rv", rsp_valid, 0);
    check("t5_busy0", busy, 0);
    check("t5_rdy", req_ready, 0);
    req_valid = '0;
    stuck = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    issue(0, 16'd12, 16'd8);
    drain();
    check("t5_z", last_z, 4);
    check("t5_id", last_id, 0);

    // Degenerate operands pass straight through.
    issue(1, 16'd0, 16'd0);
    drain();
    check("zero_z", last_z, 0);

`ifdef GCD_ARB_TIMEOUT_EN
    // 6) watchdog with a hung GCD.
    stuck = 1'b1;
    issue(2, 16'd5, 16'd3);
    drain();
    stuck = 1'b0;
    check("t6_lat", last_lat, 10);
    check("t6_z", last_z, 0);
`endif

    // Random traffic with random back-pressure.
    begin
      logic [N-1:0] rr;
      int start;
      start = n_done;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        rr = req_ready;
        @(posedge clk);
        #1;
        rsp_ready = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < N; i++) begin
          if (rr[i]) req_valid[i] = 1'b0;
          else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
            req_a[i*W +: W] = 16'($urandom);
            req_b[i*W +: W] = ($urandom_range(0, 9) == 0)
                              ? 16'd0 : 16'($urandom);
            req_valid[i] = 1'b1;
          end
        end
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      drain();
      check("rand_ops", 32'(n_done - start > 20), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
